multi_cycle_ctrl: RTL

//  Moore/Mealy FSM sequencing a multi-cycle MIPS-subset datapath (PC, IR, Reg_File, ALU, one shared memory).

---
 rtl/multi_cycle_ctrl_if.sv | 38 +++
 rtl/multi_cycle_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and its datapath/memory.
//   master : the controller (drives strobes, observes opcode/flags/ready)
//   slave  : the datapath side (observes strobes, drives opcode/flags/ready)
// Signals
//   op_i         opcode IR[31:26]        zero_i      ALU zero flag
//   mem_ready_i  memory done this cycle  pc_write_o..alu_op_o  datapath selects/strobes
interface multi_cycle_ctrl_if;
   logic [5:0] op_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       pc_write_o;
   logic       pc_src_o;
   logic       ir_write_o;
   logic       iord_o;
   logic       mem_read_o;
   logic       mem_write_o;
   logic       reg_write_o;
   logic       reg_dst_o;
   logic       mem_to_reg_o;
   logic       alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic       extend_sel_o;
   logic [2:0] alu_op_o;

   modport master (
      input  op_i, zero_i, mem_ready_i,
      output pc_write_o, pc_src_o, ir_write_o, iord_o, mem_read_o, mem_write_o,
             reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
             extend_sel_o, alu_op_o
   );

   modport slave (
      output op_i, zero_i, mem_ready_i,
      input  pc_write_o, pc_src_o, ir_write_o, iord_o, mem_read_o, mem_write_o,
             reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
             extend_sel_o, alu_op_o
   );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Sequencer for a multi-cycle MIPS-subset datapath. Each instruction walks
// FETCH -> DECODE -> (EXEC -> ALU_WB | ADDR -> MEM_RD -> LOAD_WB | ADDR -> MEM_WR
// | BRANCH) -> FETCH. Memory states wait on a variable-latency ready with an
// optional timeout; illegal opcodes and timeouts park the FSM in ERROR until reset.
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   bus            control bus (master side), see multi_cycle_ctrl_if
//   error_o        high while in ERROR
//   state_o        current state (debug)
//   retired_o      one-cycle pulse when an instruction completes
//   retire_cnt_o   retired-instruction count, wraps
module multi_cycle_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   multi_cycle_ctrl_if.master bus,
   output logic             error_o,
   output logic [3:0]       state_o,
   output logic             retired_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC    = 4'd2,
      S_ALU_WB  = 4'd3,
      S_ADDR    = 4'd4,
      S_MEM_RD  = 4'd5,
      S_MEM_WR  = 4'd6,
      S_LOAD_WB = 4'd7,
      S_BRANCH  = 4'd8,
      S_ERROR   = 4'd9
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_SLT   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;

   localparam logic [1:0] B_RT   = 2'b00;
   localparam logic [1:0] B_FOUR = 2'b01;
   localparam logic [1:0] B_IMM  = 2'b10;
   localparam logic [1:0] B_IMM4 = 2'b11;

   // Counter only has to reach TIMEOUT-1 (waits already seen before the
   // TIMEOUT-th cycle); with the timeout disabled it simply wraps.
   localparam int               WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [5:0]        op_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_state;
   logic              wait_expired;

   assign mem_state    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign wait_expired = (TIMEOUT != 0) && (wait_cnt == LAST_WAIT) && !bus.mem_ready_i;

   assign error_o = (state == S_ERROR);
   assign state_o = state;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_FETCH;
         wait_cnt     <= '0;
         retire_cnt_o <= '0;
         op_q         <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE)
            op_q <= bus.op_i;
         // Any state change clears the counter, which covers entry into
         // each waiting state.
         if (state_nxt != state)
            wait_cnt <= '0;
         else if (mem_state && !bus.mem_ready_i)
            wait_cnt <= wait_cnt + WAIT_W'(1);
         if (retired_o)
            retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt        = state;
      retired_o        = 1'b0;
      bus.pc_write_o   = 1'b0;
      bus.pc_src_o     = 1'b0;
      bus.ir_write_o   = 1'b0;
      bus.iord_o       = 1'b0;
      bus.mem_read_o   = 1'b0;
      bus.mem_write_o  = 1'b0;
      bus.reg_write_o  = 1'b0;
      bus.reg_dst_o    = 1'b0;
      bus.mem_to_reg_o = 1'b0;
      bus.alu_src_a_o  = 1'b0;
      bus.alu_src_b_o  = B_RT;
      bus.extend_sel_o = 1'b0;
      bus.alu_op_o     = ALU_ADD;
      // Under reset every strobe stays low; the register block forces FETCH.
      if (!rst_i) begin
         unique case (state)
            S_FETCH: begin
               bus.mem_read_o  = 1'b1;
               bus.alu_src_b_o = B_FOUR;
               if (bus.mem_ready_i) begin
                  bus.ir_write_o = 1'b1;
                  bus.pc_write_o = 1'b1;
                  state_nxt      = S_DECODE;
               end else if (wait_expired) begin
                  state_nxt = S_ERROR;
               end
            end
            S_DECODE: begin
               // Branch target precomputed into ALUOut.
               bus.alu_src_b_o = B_IMM4;
               case (bus.op_i)
                  OP_R, OP_ADDI, OP_SLTI, OP_ORI: state_nxt = S_EXEC;
                  OP_LW, OP_SW:                   state_nxt = S_ADDR;
                  OP_BEQ, OP_BNE:                 state_nxt = S_BRANCH;
                  default:                        state_nxt = S_ERROR;
               endcase
            end
            S_EXEC: begin
               bus.alu_src_a_o = 1'b1;
               case (op_q)
                  OP_R: begin
                     bus.alu_src_b_o = B_RT;
                     bus.alu_op_o    = ALU_FUNCT;
                  end
                  OP_ADDI: bus.alu_src_b_o = B_IMM;
                  OP_SLTI: begin
                     bus.alu_src_b_o = B_IMM;
                     bus.alu_op_o    = ALU_SLT;
                  end
                  OP_ORI: begin
                     bus.alu_src_b_o  = B_IMM;
                     bus.alu_op_o     = ALU_OR;
                     bus.extend_sel_o = 1'b1;
                  end
                  default: ;
               endcase
               state_nxt = S_ALU_WB;
            end
            S_ALU_WB: begin
               bus.reg_write_o = 1'b1;
               bus.reg_dst_o   = (op_q == OP_R);
               retired_o       = 1'b1;
               state_nxt       = S_FETCH;
            end
            S_ADDR: begin
               bus.alu_src_a_o = 1'b1;
               bus.alu_src_b_o = B_IMM;
               state_nxt       = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               bus.mem_read_o = 1'b1;
               bus.iord_o     = 1'b1;
               if (bus.mem_ready_i)
                  state_nxt = S_LOAD_WB;
               else if (wait_expired)
                  state_nxt = S_ERROR;
            end
            S_MEM_WR: begin
               bus.mem_write_o = 1'b1;
               bus.iord_o      = 1'b1;
               if (bus.mem_ready_i) begin
                  retired_o = 1'b1;
                  state_nxt = S_FETCH;
               end else if (wait_expired) begin
                  state_nxt = S_ERROR;
               end
            end
            S_LOAD_WB: begin
               bus.reg_write_o  = 1'b1;
               bus.mem_to_reg_o = 1'b1;
               retired_o        = 1'b1;
               state_nxt        = S_FETCH;
            end
            S_BRANCH: begin
               bus.alu_src_a_o = 1'b1;
               bus.alu_op_o    = ALU_SUB;
               bus.pc_src_o    = 1'b1;
               bus.pc_write_o  = ((op_q == OP_BEQ) &&  bus.zero_i) ||
                                 ((op_q == OP_BNE) && !bus.zero_i);
               retired_o       = 1'b1;
               state_nxt       = S_FETCH;
            end
            default: state_nxt = S_ERROR;   // ERROR holds; unused codes fall into it
         endcase
      end
   end

endmodule
